// File: rtl/pattern_gen_pkg.sv
// pattern_gen_pkg: mode and FSM state encodings shared by pattern_gen and pattern_step
package pattern_gen_pkg;
    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_INC   = 2'd1,
        MODE_WALK  = 2'd2,
        MODE_LFSR  = 2'd3
    } mode_t;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/pattern_step.sv
// pattern_step: combinational next-value function for every pattern mode
module pattern_step
    import pattern_gen_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY = WIDTH'(32'h8020_0003)
) (
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] next_value
);
    always_comb begin
        next_value = mode_t'(mode) == MODE_INC  ? value + WIDTH'(1) :
                     mode_t'(mode) == MODE_WALK ? {value[WIDTH-2:0], value[WIDTH-1]} :
                     mode_t'(mode) == MODE_LFSR ? (value >> 1) ^ (value[0] ? POLY : '0) :
                     value;
    end
endmodule

// File: rtl/pattern_gen.sv
// pattern_gen: burst pattern source with valid/ready output handshake
module pattern_gen
    import pattern_gen_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEN_W = 16,
    parameter logic [WIDTH-1:0] POLY = WIDTH'(32'h8020_0003)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] seed,
    input  logic [LEN_W-1:0] count,
    input  logic             abort,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done
);
    state_t           state, state_nx;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] value, next_value, first_value;
    logic [LEN_W-1:0] remaining;
    logic             xfer, accept;

    pattern_step #(.WIDTH(WIDTH), .POLY(POLY)) u_step (
        .mode       (mode_q),
        .value      (value),
        .next_value (next_value)
    );

    assign out_valid = state == ST_RUN;
    assign busy      = state == ST_RUN;
    assign done      = state == ST_DONE;
    assign out_last  = out_valid && remaining == LEN_W'(1);
    assign out_data  = value;
    assign xfer      = out_valid && out_ready;
    assign accept    = state == ST_IDLE && start && count != '0;

    // a zero seed would lock walking-one and LFSR at zero forever
    always_comb begin
        first_value = (seed == '0 && (mode_t'(mode) == MODE_WALK || mode_t'(mode) == MODE_LFSR)) ? WIDTH'(1) : seed;
    end

    always_comb begin
        state_nx = state == ST_IDLE ? (start ? (count != '0 ? ST_RUN : ST_DONE) : ST_IDLE) :
                   state == ST_RUN  ? ((abort || (xfer && out_last)) ? ST_DONE : ST_RUN) :
                   ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode_q    <= '0;
            value     <= '0;
            remaining <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                mode_q    <= mode;
                value     <= first_value;
                remaining <= count;
            end else if (xfer) begin
                value     <= next_value;
                remaining <= remaining - LEN_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: queue-model checker for pattern_gen plus literal beat checks
module tb_pattern_gen;
    localparam logic [31:0] POLY = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] seed = '0;
    logic [15:0] count = '0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid, out_last, busy, done;
    logic [31:0] out_data;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    bit          m_active = 1'b0;
    bit          m_done = 1'b0;
    int          done_cnt = 0;
    int          last_cnt = 0;

    pattern_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .seed      (seed),
        .count     (count),
        .abort     (abort),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] step(input logic [1:0] md, input logic [31:0] v);
        if (md == 2'd1) return v + 32'd1;
        if (md == 2'd2) return (v << 1) | (v >> 31);
        if (md == 2'd3) return v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
        return v;
    endfunction

    // Model: expected beats are listed up front, then consumed as transfers happen
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_active = 1'b0;
            m_done = 1'b0;
        end else if (m_active) begin
            if (out_ready) void'(exp_q.pop_front());
            if (abort || exp_q.size() == 0) begin
                m_active = 1'b0;
                m_done = 1'b1;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (start) begin
            if (count == 16'd0) begin
                m_done = 1'b1;
            end else begin
                logic [31:0] v;
                v = (seed == 32'd0 && mode >= 2'd2) ? 32'd1 : seed;
                exp_q.delete();
                for (int i = 0; i < int'(count); i++) begin
                    exp_q.push_back(v);
                    v = step(mode, v);
                end
                m_active = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] ed;
        logic        el;
        ed = (m_active && exp_q.size() > 0) ? exp_q[0] : out_data;
        el = m_active && exp_q.size() == 1;
        tests++;
        if (out_valid !== m_active || busy !== m_active || done !== m_done ||
            out_last !== el || out_data !== ed || (!rst_n && out_data !== 32'd0)) begin
            fails++;
            $display("FAIL cycle t=%0t: valid=%b busy=%b done=%b last=%b data=%h, required valid=%b busy=%b done=%b last=%b data=%h",
                     $time, out_valid, busy, done, out_last, out_data, m_active, m_active, m_done, el, ed);
        end
        if (rst_n && out_valid && out_ready) begin
            got_q.push_back(out_data);
            if (out_last) last_cnt++;
        end
        if (rst_n && done) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic burst(input logic [1:0] md, input logic [31:0] sd, input logic [15:0] cnt,
                         input bit toggle, input int abort_at);
        got_q.delete();
        done_cnt = 0;
        last_cnt = 0;
        mode = md;
        seed = sd;
        count = cnt;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        begin
            int c;
            for (c = 0; c < 500 && done_cnt == 0; c++) begin
                if (toggle) out_ready = ~out_ready;
                if (abort_at > 0 && got_q.size() >= abort_at) begin
                    abort = 1'b1;
                    out_ready = 1'b0;
                end
                @(posedge clk);
                #1;
            end
            if (c >= 500) begin
                tests++;
                fails++;
                $display("FAIL timeout: no done within %0d cycles", c);
            end
        end
        abort = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("done_pulses", 32'(done_cnt), 32'd1);
    endtask

    initial begin
        #22;
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_data", out_data, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        burst(2'd1, 32'hFFFF_FFFE, 16'd4, 1'b0, 0);
        chk("inc_n", 32'(got_q.size()), 32'd4);
        chk("inc_b0", got_q[0], 32'hFFFF_FFFE);
        chk("inc_b1", got_q[1], 32'hFFFF_FFFF);
        chk("inc_b2", got_q[2], 32'h0000_0000);
        chk("inc_b3", got_q[3], 32'h0000_0001);
        chk("inc_last", 32'(last_cnt), 32'd1);

        burst(2'd2, 32'd0, 16'd34, 1'b0, 0);
        chk("walk_n", 32'(got_q.size()), 32'd34);
        chk("walk_b0", got_q[0], 32'h0000_0001);
        chk("walk_b2", got_q[2], 32'h0000_0004);
        chk("walk_b31", got_q[31], 32'h8000_0000);
        chk("walk_b32", got_q[32], 32'h0000_0001);
        chk("walk_b33", got_q[33], 32'h0000_0002);
        chk("walk_last", 32'(last_cnt), 32'd1);

        burst(2'd3, 32'd1, 16'd3, 1'b1, 0);
        chk("lfsr_n", 32'(got_q.size()), 32'd3);
        chk("lfsr_b0", got_q[0], 32'h0000_0001);
        chk("lfsr_b1", got_q[1], 32'h8020_0003);
        chk("lfsr_b2", got_q[2], 32'hC030_0002);

        burst(2'd3, 32'd0, 16'd2, 1'b0, 0);
        chk("lfsr0_b0", got_q[0], 32'h0000_0001);

        burst(2'd0, 32'hA5A5_A5A5, 16'd10, 1'b0, 3);
        chk("abort_n", 32'(got_q.size()), 32'd3);
        chk("abort_b2", got_q[2], 32'hA5A5_A5A5);
        chk("abort_nolast", 32'(last_cnt), 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);

        // zero-length burst; start stays high into DONE, where it must be ignored
        done_cnt = 0;
        got_q.delete();
        count = 16'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("zero_done", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("zero_idle", {30'd0, busy, done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("zero_beats", 32'(got_q.size()), 32'd0);
        chk("zero_pulses", 32'(done_cnt), 32'd1);

        // reset in the middle of a burst
        done_cnt = 0;
        mode = 2'd1;
        seed = 32'd5;
        count = 16'd10;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_outs", {28'd0, out_valid, out_last, busy, done}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_no_done", 32'(done_cnt), 32'd0);
        chk("rst_idle", {31'd0, out_valid}, 32'd0);

        burst(2'd1, 32'd7, 16'd2, 1'b0, 0);
        chk("after_rst_b1", got_q[1], 32'd8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
